// File: rtl/audio_frame_writer.sv
// Audio sample RAM producer: writes per-channel samples at {chan, wr_frame}, then publishes
// the completed frame index and restarts the DSP sequencer through its active-low run input.
module audio_frame_writer #(
  parameter int unsigned CHAN_W  = 3,
  parameter int unsigned FRAME_W = 4,
  parameter int unsigned CHANS   = 8,
  parameter int unsigned AUDIO_W = CHAN_W + FRAME_W
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHAN_W-1:0]  in_chan,
  input  logic [15:0]        in_data,
  output logic [AUDIO_W-1:0] audio_waddr,
  output logic [15:0]        audio_wdata,
  output logic               audio_we,
  output logic [FRAME_W-1:0] frame,
  output logic               seq_run,
  input  logic               seq_done,
  output logic               overrun,
  output logic               chan_err,
  input  logic               err_clr
);

  typedef enum logic [1:0] {StCollect, StKick0, StKick1, StKick2} state_e;

  localparam logic [CHAN_W-1:0] LastChan = CHAN_W'(CHANS - 1);

  state_e               state_q, state_d;
  logic [CHAN_W-1:0]    exp_chan_q, exp_chan_d;
  logic [FRAME_W-1:0]   wr_frame_q, wr_frame_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 seq_run_q, seq_run_d;
  logic                 started_q, started_d;
  logic                 we_q, we_d;
  logic [AUDIO_W-1:0]   waddr_q, waddr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic                 overrun_q, overrun_d;
  logic                 chan_err_q, chan_err_d;
  logic                 accept;
  logic                 ov_set;
  logic                 ce_set;

  assign in_ready    = (state_q == StCollect);
  assign accept      = in_valid && in_ready;
  assign audio_waddr = waddr_q;
  assign audio_wdata = wdata_q;
  assign audio_we    = we_q;
  assign frame       = frame_q;
  assign seq_run     = seq_run_q;
  assign overrun     = overrun_q;
  assign chan_err    = chan_err_q;

  // Next-state: sample collection, frame publication and sticky error flags.
  always_comb begin
    state_d    = state_q;
    exp_chan_d = exp_chan_q;
    wr_frame_d = wr_frame_q;
    frame_d    = frame_q;
    seq_run_d  = seq_run_q;
    started_d  = started_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    ov_set     = 1'b0;
    ce_set     = 1'b0;

    case (state_q)
      StCollect: begin
        if (accept) begin
          // Channel 0 always resynchronises the frame, even when out of order.
          if ((in_chan == exp_chan_q) || (in_chan == '0)) begin
            if (in_chan != exp_chan_q) ce_set = 1'b1;
            we_d    = 1'b1;
            waddr_d = {in_chan, wr_frame_q};
            wdata_d = in_data;
            if (in_chan == LastChan) begin
              exp_chan_d = '0;
              state_d    = StKick0;
            end else begin
              exp_chan_d = in_chan + CHAN_W'(1);
            end
          end else begin
            ce_set     = 1'b1;
            exp_chan_d = '0;
          end
        end
      end
      StKick0: begin
        frame_d    = wr_frame_q;
        wr_frame_d = wr_frame_q + FRAME_W'(1);
        seq_run_d  = 1'b0;
        if (started_q && !seq_done) ov_set = 1'b1;
        started_d  = 1'b1;
        state_d    = StKick1;
      end
      StKick1: begin
        state_d = StKick2;
      end
      StKick2: begin
        seq_run_d = 1'b1;
        state_d   = StCollect;
      end
      default: begin
        state_d = StCollect;
      end
    endcase

    // A set on the same edge wins over a clear.
    overrun_d  = ov_set | (overrun_q & ~err_clr);
    chan_err_d = ce_set | (chan_err_q & ~err_clr);
  end

  // State and registered outputs.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q    <= StCollect;
      exp_chan_q <= '0;
      wr_frame_q <= '0;
      frame_q    <= '0;
      seq_run_q  <= 1'b0;
      started_q  <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      overrun_q  <= 1'b0;
      chan_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_chan_q <= exp_chan_d;
      wr_frame_q <= wr_frame_d;
      frame_q    <= frame_d;
      seq_run_q  <= seq_run_d;
      started_q  <= started_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      overrun_q  <= overrun_d;
      chan_err_q <= chan_err_d;
    end
  end

endmodule

// File: doc/audio_frame_writer.md
Name: audio_frame_writer

Overview:
- Producer side of the audio sample RAM that the DSP sequencer reads.
- Accepts one 16-bit sample per channel per frame on a valid/ready stream and writes each sample to the RAM at {chan, wr_frame}.
- When a frame is complete, publishes the frame index and restarts the sequencer through its active-low run input.
- Flags overruns, when the sequencer has not finished before the next restart, and channel-order errors.

Parameters:
- CHAN_W, 3, channel index width.
- FRAME_W, 4, frame index width; the RAM holds 2^FRAME_W frames per channel.
- CHANS, 8, channels per frame; must satisfy 1 <= CHANS <= 2^CHAN_W.
- AUDIO_W, CHAN_W+FRAME_W, audio RAM write address width.

Ports:
- ck  in  1  system clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample this cycle.
- in_chan  in  CHAN_W  channel of the presented sample.
- in_data  in  16  sample value, two's complement.
- audio_waddr  out  AUDIO_W  RAM write address {chan, wr_frame}.
- audio_wdata  out  16  RAM write data.
- audio_we  out  1  RAM write strobe, one cycle per sample.
- frame  out  FRAME_W  most recently completed frame index, fed to the sequencer.
- seq_run  out  1  sequencer run enable, active-low reset to the sequencer.
- seq_done  in  1  sequencer has halted.
- overrun  out  1  sticky error flag.
- chan_err  out  1  sticky error flag.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- States: COLLECT, KICK0, KICK1, KICK2.
- in_ready = (state == COLLECT), decoded combinationally from the state register.
- Reset values (asynchronous): state = COLLECT, so in_ready = 1. expected_chan = 0, wr_frame = 0, frame = 0, seq_run = 0 (sequencer held until the first frame), started = 0, audio_we = 0, audio_waddr = 0, audio_wdata = 0, overrun = 0, chan_err = 0.
- An accept occurs at a posedge where in_valid && in_ready.
- Accept with in_chan == expected_chan:
  - Registered write on the following cycle: audio_we = 1, audio_waddr = {in_chan, wr_frame}, audio_wdata = in_data.
  - Latency from accept edge to strobe is one cycle. audio_we is high for exactly one cycle per write, and address/data hold their last values when audio_we is low.
- Accept with in_chan != expected_chan:
  - chan_err <= 1; the sample is discarded and no write occurs.
  - Exception: if in_chan == 0, the frame is resynchronised. The sample is written as channel 0 and expected_chan <= 1.
  - Otherwise expected_chan <= 0.
- Accept of channel CHANS-1 that is written:
  - expected_chan <= 0, state <= KICK0.
- Channels below CHANS-1: expected_chan increments.
- KICK0 edge:
  - frame <= wr_frame; wr_frame <= wr_frame + 1, wrapping from 2^FRAME_W-1 to 0.
  - seq_run <= 0.
  - If started && !seq_done, then overrun <= 1.
  - started <= 1; state <= KICK1.
- KICK1 edge: state <= KICK2; seq_run stays 0.
- KICK2 edge: seq_run <= 1; state <= COLLECT.
- Net effect per frame: seq_run is low for exactly 2 cycles and in_ready is low for exactly 3 cycles. The last write strobe precedes the seq_run fall by one cycle.
- No RAM write occurs while seq_run is high for a frame whose index equals frame, so the sequencer never reads a partially written frame. Its offsets index backwards through wr_frame history.
- err_clr has priority below a same-edge set: a flag set and cleared on the same edge ends at 1.
- CHANS == 1: every valid channel-0 accept completes a frame.
- rst asserted mid-frame or in a KICK state: immediate return to reset values. Partial frame writes already in the RAM are left as is and are not replayed.

Test Plan:
- Reset, then stream 8 in-order samples (chan 0..7, data 16'h1000+chan) with in_valid held high -> 8 single-cycle writes to addr {chan, 4'h0}, each one cycle after its accept. frame = 0, seq_run 0 -> 0 -> 1 after KICK2, overrun = 0.
- 17 complete frames with seq_done pulsed high before each KICK0 -> frame sequence 0..15, 0. Writes for frame 16 use wr_frame 0 (wrap). Errors remain 0.
- Second frame completes while seq_done = 0 -> overrun = 1 at the KICK0 edge. Assert err_clr the following cycle -> overrun = 0.
- Sequence chan 0, 1, 3 -> chan 3 is not written and chan_err = 1. Next chan 0 is accepted and written as {0, wr_frame}, and expected_chan = 1.
- in_valid high during KICK0..KICK2 -> in_ready = 0 for exactly 3 cycles and no accept. The held sample is accepted in the first COLLECT cycle.
- Assert rst asynchronously mid-frame, between clock edges, after chan 4 -> outputs take reset values immediately. The next frame starts at chan 0 with wr_frame = 0.
